// File: rtl/mmux.sv
// ---------------------------------------------------------------------------
// mmux -- 4:1 multiplexer with a combinational output and a registered copy.
//
// The select path is built as explicit gate structure: the two select bits
// are inverted, each lane is gated by a 3-input AND of the appropriate select
// literals, and the four gated lanes are ORed per output bit.  OUT and SEL_OH
// depend only on S and I, so they stay valid with the clock stopped and are
// unaffected by rst.  OUT_Q/SEL_Q capture OUT/S on enabled edges.
//
// Ports
//   clk     in   1        clock, all state updates on the rising edge
//   rst     in   1        synchronous active-high reset of OUT_Q / SEL_Q
//   OUT     out  DATA_W   combinational selected lane (lane S of I)
//   S       in   2        lane select, S[1] is the MSB
//   I       in   4*DATA_W four lanes, lane k = I[k*DATA_W +: DATA_W]
//   en      in   1        capture enable for OUT_Q / SEL_Q
//   OUT_Q   out  DATA_W   registered OUT, one-cycle latency
//   SEL_OH  out  4        one-hot decode of S (bit k high when S == k)
//   SEL_Q   out  2        S value captured together with OUT_Q
// ---------------------------------------------------------------------------
module mmux #(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_W-1:0]     OUT,
    input  logic [1:0]            S,
    input  logic [4*DATA_W-1:0]   I,
    input  logic                  en,
    output logic [DATA_W-1:0]     OUT_Q,
    output logic [3:0]            SEL_OH,
    output logic [1:0]            SEL_Q
);

    logic              w_s1_n;
    logic              w_s0_n;
    logic [DATA_W-1:0] w_and0;
    logic [DATA_W-1:0] w_and1;
    logic [DATA_W-1:0] w_and2;
    logic [DATA_W-1:0] w_and3;

    logic [DATA_W-1:0] r_out_q;
    logic [1:0]        r_sel_q;

    // Select literal inverters.
    assign w_s1_n = ~S[1];
    assign w_s0_n = ~S[0];

    // One 3-input AND term per lane, replicated across every data bit so
    // each bit of the datapath is an independent 4:1 mux.
    assign w_and0 = {DATA_W{w_s1_n}} & {DATA_W{w_s0_n}} & I[0*DATA_W +: DATA_W];
    assign w_and1 = {DATA_W{w_s1_n}} & {DATA_W{S[0]}}   & I[1*DATA_W +: DATA_W];
    assign w_and2 = {DATA_W{S[1]}}   & {DATA_W{w_s0_n}} & I[2*DATA_W +: DATA_W];
    assign w_and3 = {DATA_W{S[1]}}   & {DATA_W{S[0]}}   & I[3*DATA_W +: DATA_W];

    // 4-input OR per output bit; exactly one term can be active.
    assign OUT = w_and0 | w_and1 | w_and2 | w_and3;

    // One-hot decode reuses the same select literals.
    assign SEL_OH = {S[1] & S[0], S[1] & w_s0_n, w_s1_n & S[0], w_s1_n & w_s0_n};

    // Registered copy: reset wins over enable; disabled edges hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q <= '0;
            r_sel_q <= 2'b00;
        end else if (en) begin
            r_out_q <= OUT;
            r_sel_q <= S;
        end
    end

    assign OUT_Q = r_out_q;
    assign SEL_Q = r_sel_q;

endmodule

// File: tb/tb_mmux.sv
module tb_mmux;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic       en;

    // DATA_W = 1 instance
    logic [0:0] out1;
    logic [1:0] s1;
    logic [3:0] i1;
    logic [0:0] out_q1;
    logic [3:0] sel_oh1;
    logic [1:0] sel_q1;

    // DATA_W = 8 instance
    logic [7:0]  out8;
    logic [1:0]  s8;
    logic [31:0] i8;
    logic [7:0]  out_q8;
    logic [3:0]  sel_oh8;
    logic [1:0]  sel_q8;

    int vectors;
    int miscompares;

    mmux #(.DATA_W(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .OUT    (out1),
        .S      (s1),
        .I      (i1),
        .en     (en),
        .OUT_Q  (out_q1),
        .SEL_OH (sel_oh1),
        .SEL_Q  (sel_q1)
    );

    mmux #(.DATA_W(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .OUT    (out8),
        .S      (s8),
        .I      (i8),
        .en     (en),
        .OUT_Q  (out_q8),
        .SEL_OH (sel_oh8),
        .SEL_Q  (sel_q8)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    // Combinational path with the clock stopped.
    task automatic test_comb_noclk();
        logic [1:0] s_tab [4];
        logic       o_tab [4];
        logic [3:0] oh_tab [4];
        s_tab  = '{2'b00, 2'b01, 2'b10, 2'b11};
        o_tab  = '{1'b0, 1'b1, 1'b0, 1'b1};
        oh_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        i1 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            s1 = s_tab[k];
            #5;
            vectors++;
            if (out1 !== o_tab[k]) begin
                miscompares++;
                $display("FAIL comb_out S=%b got=%b exp=%b", s1, out1, o_tab[k]);
            end
            vectors++;
            if (sel_oh1 !== oh_tab[k]) begin
                miscompares++;
                $display("FAIL comb_seloh S=%b got=%b exp=%b", s1, sel_oh1, oh_tab[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0;
        i1 = 4'b1010; s1 = 2'b11;
        @(posedge clk); #1;
        vectors++;
        if (out_q1 !== 1'b0 || sel_q1 !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state got OUT_Q=%b SEL_Q=%b exp 0/00", out_q1, sel_q1);
        end
        vectors++;
        if (out1 !== 1'b1 || sel_oh1 !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_comb got OUT=%b SEL_OH=%b exp 1/1000", out1, sel_oh1);
        end
    endtask

    task automatic test_capture();
        rst = 1'b0; en = 1'b1;
        i1 = 4'b1010; s1 = 2'b01;
        #1;
        vectors++;
        if (out_q1 !== 1'b0) begin
            miscompares++;
            $display("FAIL capture_pre got OUT_Q=%b exp 0", out_q1);
        end
        @(posedge clk); #1;
        vectors++;
        if (out_q1 !== 1'b1 || sel_q1 !== 2'b01) begin
            miscompares++;
            $display("FAIL capture got OUT_Q=%b SEL_Q=%b exp 1/01", out_q1, sel_q1);
        end
    endtask

    task automatic test_hold();
        en = 1'b1; s1 = 2'b11;
        @(posedge clk); #1;
        vectors++;
        if (out_q1 !== 1'b1 || sel_q1 !== 2'b11) begin
            miscompares++;
            $display("FAIL hold_load got OUT_Q=%b SEL_Q=%b exp 1/11", out_q1, sel_q1);
        end
        en = 1'b0; s1 = 2'b00;
        #1;
        vectors++;
        if (out1 !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_comb got OUT=%b exp 0", out1);
        end
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_q1 !== 1'b1 || sel_q1 !== 2'b11) begin
                miscompares++;
                $display("FAIL hold_edge%0d got OUT_Q=%b SEL_Q=%b exp 1/11", e, out_q1, sel_q1);
            end
        end
    endtask

    task automatic test_reset_priority();
        en = 1'b1; s1 = 2'b01; i1 = 4'b1010;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (out_q1 !== 1'b0 || sel_q1 !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_prio got OUT_Q=%b SEL_Q=%b exp 0/00", out_q1, sel_q1);
        end
        vectors++;
        if (out1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_prio_comb got OUT=%b exp 1", out1);
        end
        s1 = 2'b10; #1;
        vectors++;
        if (out1 !== 1'b0 || sel_oh1 !== 4'b0100) begin
            miscompares++;
            $display("FAIL rst_track got OUT=%b SEL_OH=%b exp 0/0100", out1, sel_oh1);
        end
        // First enabled edge after reset release captures again.
        rst = 1'b0; s1 = 2'b11;
        @(posedge clk); #1;
        vectors++;
        if (out_q1 !== 1'b1 || sel_q1 !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_resume got OUT_Q=%b SEL_Q=%b exp 1/11", out_q1, sel_q1);
        end
    endtask

    task automatic test_w8();
        logic [7:0] exp_tab [4];
        exp_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
        i8 = 32'h44332211;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s8 = 2'(k);
            #1;
            vectors++;
            if (out8 !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL w8_out S=%0d got=%h exp=%h", k, out8, exp_tab[k]);
            end
        end
        s8 = 2'b10;
        @(posedge clk); #1;
        vectors++;
        if (out_q8 !== 8'h33 || sel_q8 !== 2'b10) begin
            miscompares++;
            $display("FAIL w8_capture got OUT_Q=%h SEL_Q=%b exp 33/10", out_q8, sel_q8);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] iv;
        logic [3:0] oh;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 4; b++) begin
                iv = 4'(a);
                i1 = iv;
                s1 = 2'(b);
                oh = 4'b0001 << b;
                #1;
                vectors++;
                if (out1 !== iv[b] || sel_oh1 !== oh) begin
                    miscompares++;
                    $display("FAIL sweep I=%b S=%0d got OUT=%b SEL_OH=%b exp %b/%b",
                             iv, b, out1, sel_oh1, iv[b], oh);
                end
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        clk_run = 1'b0;
        rst = 1'b0; en = 1'b0;
        s1 = 2'b00; i1 = 4'b0000;
        s8 = 2'b00; i8 = 32'h0;
        test_comb_noclk();
        clk_run = 1'b1;
        @(negedge clk);
        test_reset();
        test_capture();
        test_hold();
        test_reset_priority();
        test_w8();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmux.md
MMUX -- requirements
Module: mmux

Interface
Parameters:
REQ-001 SHALL have parameter DATA_W, default 1, giving the width of each data input lane and of each data output.

Ports:
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port en, input, 1 bit: capture enable for the registered path.
REQ-005 SHALL have port OUT, output, DATA_W bits: combinational selected data.
REQ-006 SHALL have port S, input, 2 bits: select; S[1] is the MSB.
REQ-007 SHALL have port I, input, 4*DATA_W bits: lane k = I[k*DATA_W +: DATA_W], for k = 0..3.
REQ-008 SHALL have port OUT_Q, output, DATA_W bits: registered copy of the selected data.
REQ-009 SHALL have port SEL_OH, output, 4 bits: one-hot decode of S; bit k is high when S == k.
REQ-010 SHALL have port SEL_Q, output, 2 bits: S value captured with OUT_Q.
REQ-011 SHALL keep the relative port order OUT, S, I after clk and rst.

Function
REQ-012 SHALL drive OUT = lane S of I, combinationally, with no clock dependency and no latency.
REQ-013 SHALL make OUT independent of clk, rst and en, so OUT is valid with the clock stopped.
REQ-014 SHALL build the select path as gate-level structure: inverters on S[1] and S[0]; four 3-input AND terms (S1', S0', lane); a 4-input OR per output bit.
REQ-015 SHALL drive SEL_OH combinationally; exactly one bit is high for every S value.
REQ-016 SHALL, on a rising clk edge with rst = 0 and en = 1, load OUT_Q with the current OUT and SEL_Q with the current S.
REQ-017 SHALL, on a rising clk edge with rst = 0 and en = 0, hold OUT_Q and SEL_Q unchanged.
REQ-018 SHALL give OUT_Q one-cycle latency: OUT_Q after edge n equals OUT sampled just before edge n.
REQ-019 SHALL let a change of S or I between edges affect OUT immediately and OUT_Q only at the next enabled edge.
REQ-020 SHALL make every DATA_W bit independent; there is no arithmetic and no width extension.
REQ-021 SHALL NOT produce X on any output when all inputs are known 0/1.

Reset
REQ-022 SHALL, on a rising clk edge with rst = 1, clear OUT_Q and SEL_Q to all zeros, regardless of en.
REQ-023 SHALL give rst priority over en when both are asserted.
REQ-024 SHALL leave OUT and SEL_OH unaffected by rst; they always follow S and I.
REQ-025 SHALL, on rst deassertion, resume normal capture at the first enabled edge after the reset edge.
REQ-026 SHALL, if rst is asserted mid-operation, discard held data and clear OUT_Q and SEL_Q at that edge.

Verification
REQ-027 SHALL cover DATA_W = 1 with I = 4'b1010 and S stepped 00, 01, 10, 11, 5 time units each, no clock: OUT = 0, 1, 0, 1 and SEL_OH = 0001, 0010, 0100, 1000.
REQ-028 SHALL cover the registered path: rst = 1 for one edge, then en = 1, I = 4'b1010, S = 01. Required: OUT_Q = 0 and SEL_Q = 00 after the reset edge, then OUT_Q = 1 and SEL_Q = 01 after the next edge.
REQ-029 SHALL cover hold: capture with S = 11 (OUT_Q = 1), then en = 0 and S = 00. Required: OUT = 0 immediately; OUT_Q stays 1 and SEL_Q stays 11 over 3 edges.
REQ-030 SHALL cover reset priority: rst = 1 and en = 1 together with OUT_Q = 1. Required: OUT_Q = 0 and SEL_Q = 00 after the edge; OUT still tracks lane S.
REQ-031 SHALL cover DATA_W = 8 with lanes 0x11, 0x22, 0x33, 0x44 and S = 0..3: OUT = 0x11, 0x22, 0x33, 0x44.
REQ-032 SHALL cover an exhaustive sweep at DATA_W = 1 over all 16 I values × 4 S values: OUT == I[S] in every case.
